// File: rtl/uart_tx_sequencer.sv
// 8N1 UART transmitter shared by two requesters through a round-robin arbiter.
// One frame is in flight at a time; ena low stalls the whole sequencer in place.
module uart_tx_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] gnt,
  output logic       owner,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam logic [7:0] BaudMax = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic       done_q, done_d;
  logic       tx_q, tx_d;

  logic       any_req;
  logic       winner;
  logic       baud_wrap;

  always_comb begin
    any_req = |req;
    // On a tie the requester that was not served last goes first.
    if (req == 2'b11) begin
      winner = ~last_q;
    end else begin
      winner = req[1];
    end
  end

  assign baud_wrap = (baud_q == BaudMax);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = 2'b00;
    done_d  = 1'b0;

    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_d = StStart;
            byte_d  = winner ? data1 : data0;
            owner_d = winner;
            last_d  = winner;
            gnt_d   = winner ? 2'b10 : 2'b01;
            baud_d  = '0;
            bit_d   = '0;
          end
        end
        StStart: begin
          if (baud_wrap) begin
            state_d = StData;
            baud_d  = '0;
            bit_d   = '0;
          end else begin
            baud_d = baud_q + 8'd1;
          end
        end
        StData: begin
          if (baud_wrap) begin
            baud_d = '0;
            if (bit_q == 3'd7) begin
              state_d = StStop;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            baud_d = baud_q + 8'd1;
          end
        end
        StStop: begin
          if (baud_wrap) begin
            state_d = StIdle;
            baud_d  = '0;
            done_d  = 1'b1;
          end else begin
            baud_d = baud_q + 8'd1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Line level is registered from the next state so tx never glitches.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = byte_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign tx    = tx_q;

`ifndef SYNTHESIS
  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) gnt != 2'b11);
  gnt_done_a:   assert property (@(posedge clk) disable iff (!rst_n) !((|gnt) && done));
  baud_range_a: assert property (@(posedge clk) disable iff (!rst_n) baud_q <= BaudMax);
`endif

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_sequencer;

  localparam int Cpb      = 4;
  localparam int FrameLen = 10 * Cpb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena;
  logic [1:0] req;
  logic [7:0] data0, data1;
  logic [1:0] gnt;
  logic       owner, busy, done, tx;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  uart_tx_sequencer #(.CLKS_PER_BIT(Cpb)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .req   (req),
    .data0 (data0),
    .data1 (data1),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just a position counter over 10 bit slots.
  bit         m_busy  = 1'b0;
  int         m_pos   = 0;
  logic [7:0] m_byte  = 8'h00;
  bit         m_owner = 1'b0;
  bit         m_last  = 1'b1;
  logic [1:0] m_gnt   = 2'b00;
  bit         m_done  = 1'b0;
  bit         m_w;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_pos = 0; m_byte = 8'h00; m_owner = 1'b0;
      m_last = 1'b1; m_gnt = 2'b00; m_done = 1'b0;
    end else begin
      m_gnt  = 2'b00;
      m_done = 1'b0;
      if (ena) begin
        if (!m_busy) begin
          if (req != 2'b00) begin
            if (req == 2'b01)      m_w = 1'b0;
            else if (req == 2'b10) m_w = 1'b1;
            else                   m_w = !m_last;
            m_busy  = 1'b1;
            m_pos   = 0;
            m_owner = m_w;
            m_last  = m_w;
            m_byte  = m_w ? data1 : data0;
            m_gnt   = m_w ? 2'b10 : 2'b01;
          end
        end else begin
          m_pos++;
          if (m_pos == FrameLen) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx", tx, m_busy ? frame_bit(m_byte, m_pos / Cpb) : 1'b1);
      chk("busy", busy, m_busy);
      chk("gnt", gnt, m_gnt);
      chk("done", done, m_done);
      chk("owner", owner, m_owner);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt();
    bit found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (gnt != 2'b00) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: actual no grant required grant within 20 cycles");
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int n = 0; n < 120 && !idle; n++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: actual busy required idle within 120 cycles");
    end
    @(negedge clk);
  endtask

  // Entered at the negedge of the grant cycle (first tx=0 cycle).
  task automatic capture(input int pause_at, input int pause_len, output logic [9:0] frame,
                         output int busy_cnt, output int done_at);
    logic smp[$];
    busy_cnt = 0;
    done_at  = -1;
    frame    = 'x;
    for (int n = 0; n <= FrameLen + pause_len; n++) begin
      if (busy) busy_cnt++;
      if (done && done_at < 0) done_at = n;
      if (pause_len == 0 || n <= pause_at || n > pause_at + pause_len) smp.push_back(tx);
      if (n == pause_at) ena = 1'b0;
      if (pause_len > 0 && n == pause_at + pause_len) ena = 1'b1;
      if (n < FrameLen + pause_len) @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      frame[k] = (smp.size() > Cpb * k + Cpb / 2) ? smp[Cpb * k + Cpb / 2] : 1'bx;
    end
  endtask

  initial begin
    logic [9:0] fr;
    int         bc, da, nfound, gcnt, txlow, dcnt;
    logic [1:0] g[3];
    logic       o[3];
    int         t[3];
    bit         seen_idle;

    ena = 1'b0; req = 2'b00; data0 = 8'h00; data1 = 8'h00;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 1'b0);
    chk("rst_owner", owner, 1'b0);
    rst_n = 1'b1;

    // Single request, 0xA5.
    @(negedge clk);
    ena = 1'b1; data0 = 8'hA5; req = 2'b01;
    wait_gnt();
    chk("a5_gnt", gnt, 2'b01);
    req = 2'b00;
    capture(-1, 0, fr, bc, da);
    chk("a5_frame", fr, 10'b1101001010);
    chk("a5_busy_cycles", bc, 40);
    chk("a5_done_at", da, 40);

    // Both requesting from reset: alternate, 41 cycles apart.
    req = 2'b11; ena = 1'b1; data0 = 8'h11; data1 = 8'h22;
    do_reset();
    nfound = 0;
    for (int n = 0; n < 200 && nfound < 3; n++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        g[nfound] = gnt; o[nfound] = owner; t[nfound] = n; nfound++;
      end
    end
    req = 2'b00;
    chk("rr_count", nfound, 3);
    if (nfound == 3) begin
      chk("rr_g0", g[0], 2'b01);
      chk("rr_g1", g[1], 2'b10);
      chk("rr_g2", g[2], 2'b01);
      chk("rr_o0", o[0], 1'b0);
      chk("rr_o1", o[1], 1'b1);
      chk("rr_o2", o[2], 1'b0);
      chk("rr_gap01", t[1] - t[0], 41);
      chk("rr_gap12", t[2] - t[1], 41);
    end
    wait_idle();

    // ena low for 5 cycles in DATA bit 3.
    data0 = 8'h5A; req = 2'b01;
    wait_gnt();
    req = 2'b00;
    capture(18, 5, fr, bc, da);
    chk("stall_frame", fr, 10'b1010110100);
    chk("stall_busy_cycles", bc, 45);
    chk("stall_done_at", da, 45);
    wait_idle();

    // data0 changed during START.
    data0 = 8'h3C; req = 2'b01;
    wait_gnt();
    req = 2'b00; data0 = 8'hFF;
    capture(-1, 0, fr, bc, da);
    chk("latch_frame", fr, 10'b1001111000);
    wait_idle();

    // Short request while busy is dropped.
    data0 = 8'h11; req = 2'b01;
    wait_gnt();
    req = 2'b00;
    repeat (10) @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    gcnt = 0; txlow = 0; seen_idle = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (gnt != 2'b00) gcnt++;
      if (!busy) seen_idle = 1'b1;
      if (seen_idle && tx == 1'b0) txlow++;
    end
    chk("drop_gnts", gcnt, 0);
    chk("drop_tx_low", txlow, 0);

    // Reset during DATA bit 2.
    data0 = 8'h96; req = 2'b01;
    wait_gnt();
    req = 2'b00;
    repeat (13) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    dcnt = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);
    req = 2'b10; data1 = 8'hC3;
    wait_gnt();
    chk("midrst_gnt", gnt, 2'b10);
    chk("midrst_owner", owner, 1'b1);
    req = 2'b00;
    wait_idle();

    // Randomized traffic with stalls, drops and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ena = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 2; i++) begin
        if (gnt[i])                         req[i] = 1'b0;
        else if (!req[i])                   req[i] = ($urandom_range(0, 5) == 0);
        else if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) data0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) data1 = 8'($urandom);
      if ($urandom_range(0, 1499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    req = 2'b00; ena = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
